fd_pipe_stage: RTL and testbench
================================

# fd_pipe_stage

Parametrised fetch/decode pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush, and bubble insertion. It sits between fetch and decode and carries the instruction word and next-PC. It absorbs one cycle of downstream back-pressure without data loss, so the `in_ready` path toward fetch is fully registered. When no valid instruction is present it presents a programmable NOP to decode.

## Interface
Parameters:
- `IR_WIDTH`, 32: instruction word width.
- `PC_WIDTH`, 32: next-PC width.
- `NOP_INSTR`, 0 (IR_WIDTH bits): instruction word driven on `out_IR` whenever `out_valid`=0.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the rising edge of `clock`.
- `flush`  in  1: discard all held entries (branch mispredict or exception).
- `in_valid`  in  1: fetch presents a valid instruction.
- `in_ready`  out  1: stage accepts input this cycle; driven directly from state, no combinational path from `out_ready`.
- `in_IR`  in  IR_WIDTH: instruction from fetch.
- `in_PC_next`  in  PC_WIDTH: next-PC from fetch.
- `out_valid`  out  1: decode-side entry is valid.
- `out_ready`  in  1: decode consumes the entry this cycle.
- `out_IR`  out  IR_WIDTH: head instruction, or `NOP_INSTR` when `out_valid`=0.
- `out_PC_next`  out  PC_WIDTH: head next-PC, or 0 when `out_valid`=0.
- `occupancy`  out  2: number of held entries (0, 1 or 2).

## Operation
- Storage: main entry (head, drives outputs) and skid entry. Each holds IR and PC_next.
- States:
  - EMPTY (occupancy 0)
  - ONE (main valid)
  - FULL (main and skid valid)
- Handshake definitions:
  - acc = `in_valid` & `in_ready`
  - deq = `out_valid` & `out_ready`
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL.
- `out_valid` = 1 in ONE and FULL.
- Transitions when `flush`=0:
  - EMPTY: acc -> ONE, and main loads the input.
  - ONE, acc & deq -> ONE; main loads the input.
  - ONE, acc & !deq -> FULL; skid loads the input.
  - ONE, !acc & deq -> EMPTY.
  - ONE, !acc & !deq -> ONE; hold.
  - FULL, deq -> ONE; main loads from skid.
  - FULL, !deq -> FULL; hold.
  - No input is accepted in FULL.
- Ordering: strict FIFO. Skid content always reaches decode before any later input.
- `flush`=1 (and `reset` high): next state EMPTY regardless of acc or deq. An input offered in the same cycle is dropped. A dequeue in the same cycle still completes from decode's view.
- Priority: `reset` > `flush` > normal handshake.
- Stored registers not being loaded hold their value. No data-dependent modification of IR or PC_next.

## Timing
- Reset: on a rising edge with `reset`=0, state becomes EMPTY. From that edge:
  - `out_valid`=0
  - `out_IR`=`NOP_INSTR`
  - `out_PC_next`=0
  - `occupancy`=0
  - `in_ready`=1
- Reset asserted mid-operation discards both entries at that edge. No partial update occurs.
- Latency: data accepted at edge N appears on the outputs after edge N. This holds in EMPTY, and in ONE with simultaneous dequeue. It is one cycle, matching a plain pipeline latch.
- Throughput: one instruction per cycle while `out_ready`=1.
- Back-pressure: `out_ready` falling is absorbed by the skid entry. `in_ready` drops on the following cycle, never combinationally.
- Flush: outputs show NOP and `out_valid`=0 on the cycle after the flush edge. `in_ready`=1 on that cycle.
- Ready/valid at both interfaces follows standard rules:
  - The stage never retracts `out_valid`, and never changes `out_IR` or `out_PC_next`, while `out_valid`=1 and `out_ready`=0, unless a flush or reset occurs.

## Test plan
- Reset: hold `reset`=0 for 2 edges with `in_valid`=1 and `in_IR`=0xDEADBEEF, then release. Required: `out_valid`=0, `out_IR`=`NOP_INSTR`, `occupancy`=0, `in_ready`=1. Nothing is accepted during reset.
- Streaming: `out_ready`=1 and `in_valid`=1 with IR 0x100..0x107 on consecutive cycles. Required: `out_IR` shows 0x100..0x107 one cycle later each, in order, with `out_valid` continuous.
- Back-pressure: push 0xA0, 0xA1, 0xA2 while `out_ready`=0 from the second cycle. Required:
  - `occupancy` goes 1, 2.
  - `in_ready`=0 while 0xA2 is offered; 0xA2 is not accepted.
  - After `out_ready`=1, decode sees 0xA0, 0xA1, then 0xA2 after it is re-accepted.
- Flush from FULL: occupancy 2 (0xB0, 0xB1), assert `flush` with `in_valid`=1 and IR 0xB2. Required next cycle: `out_valid`=0, `out_IR`=`NOP_INSTR`, `occupancy`=0. 0xB2 is never output.
- Simultaneous acc and deq in ONE: hold 0xC0, offer 0xC1 with `out_ready`=1. Required: `occupancy` stays 1 and `out_IR`=0xC1 next cycle.
- Reset mid-FULL: occupancy 2, pull `reset` low for one edge. Required: all outputs at reset values on the next cycle. Stale 0xB-series data is never output.

Source files
------------

// File: rtl/fd_pipe_stage_if.sv
// Fetch-to-decode handshake bundle: fetch drives the in_* side, decode consumes the out_* side.
// The stage itself binds to the slave modport; the surrounding logic or the bench takes master.
interface fd_pipe_stage_if #(
   parameter int IR_WIDTH = 32,
   parameter int PC_WIDTH = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [IR_WIDTH-1:0] in_IR;
   logic [PC_WIDTH-1:0] in_PC_next;
   logic                out_valid;
   logic                out_ready;
   logic [IR_WIDTH-1:0] out_IR;
   logic [PC_WIDTH-1:0] out_PC_next;

   modport master (
      output in_valid, in_IR, in_PC_next, out_ready,
      input  in_ready, out_valid, out_IR, out_PC_next
   );

   modport slave (
      input  in_valid, in_IR, in_PC_next, out_ready,
      output in_ready, out_valid, out_IR, out_PC_next
   );
endinterface

// File: rtl/fd_pipe_stage.sv
// Fetch/decode stage register with a two-entry skid buffer; one-cycle latency, NOP when empty.
// Back-pressure: the skid entry absorbs one stalled cycle, so in_ready comes straight from state.
module fd_pipe_stage #(
   parameter int                  IR_WIDTH  = 32,
   parameter int                  PC_WIDTH  = 32,
   parameter logic [IR_WIDTH-1:0] NOP_INSTR = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   fd_pipe_stage_if.slave       bus,
   output logic [1:0]           occupancy
);

   typedef struct packed {
      logic [IR_WIDTH-1:0] ir;
      logic [PC_WIDTH-1:0] pc;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   entry_t main_q;
   entry_t skid_q;
   entry_t in_ent;

   logic in_rdy;
   logic out_vld;
   logic acc;
   logic deq;
   logic load_main_in;
   logic load_main_skid;
   logic load_skid;

   assign in_ent = '{ir: bus.in_IR, pc: bus.in_PC_next};
   assign acc    = bus.in_valid & in_rdy;
   assign deq    = out_vld & bus.out_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         unique case (state)
            ST_EMPTY: if (acc) state_nxt = ST_ONE;
            ST_ONE: begin
               if (acc && !deq)      state_nxt = ST_FULL;
               else if (!acc && deq) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (deq) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_comb begin
      in_rdy    = 1'b1;
      out_vld   = 1'b0;
      occupancy = 2'd0;
      unique case (state)
         ST_EMPTY: begin
            in_rdy    = 1'b1;
            out_vld   = 1'b0;
            occupancy = 2'd0;
         end
         ST_ONE: begin
            in_rdy    = 1'b1;
            out_vld   = 1'b1;
            occupancy = 2'd1;
         end
         ST_FULL: begin
            in_rdy    = 1'b0;
            out_vld   = 1'b1;
            occupancy = 2'd2;
         end
         default: begin
            in_rdy    = 1'b1;
            out_vld   = 1'b0;
            occupancy = 2'd0;
         end
      endcase
   end

   // Data loads are gated by both resets so an entry offered alongside them is dropped.
   assign load_main_in   = reset && !flush &&
                           (((state == ST_EMPTY) && acc) || ((state == ST_ONE) && acc && deq));
   assign load_skid      = reset && !flush && (state == ST_ONE) && acc && !deq;
   assign load_main_skid = reset && !flush && (state == ST_FULL) && deq;

   always_ff @(posedge clock) begin
      if (load_main_in) begin
         main_q <= in_ent;
      end else if (load_main_skid) begin
         main_q <= skid_q;
      end
      if (load_skid) begin
         skid_q <= in_ent;
      end
   end

   always_comb begin
      bus.in_ready    = in_rdy;
      bus.out_valid   = out_vld;
      bus.out_IR      = out_vld ? main_q.ir : NOP_INSTR;
      bus.out_PC_next = out_vld ? main_q.pc : '0;
   end

endmodule

// File: tb/tb_fd_pipe_stage.sv
// Randomized and directed bench for fd_pipe_stage against a queue-based reference model.
module tb_fd_pipe_stage;
   localparam int          IRW = 32;
   localparam int          PCW = 32;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [IRW-1:0] ir;
      logic [PCW-1:0] pc;
   } ent_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] occupancy;

   fd_pipe_stage_if #(.IR_WIDTH(IRW), .PC_WIDTH(PCW)) bus ();

   fd_pipe_stage #(
      .IR_WIDTH (IRW),
      .PC_WIDTH (PCW),
      .NOP_INSTR(NOP)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .bus      (bus.slave),
      .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;
   bit   armed = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      bit exp_v;
      exp_v = (q.size() > 0);
      check("out_valid", 64'(bus.out_valid), 64'(exp_v));
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      check("occupancy", 64'(occupancy), 64'(q.size()));
      if (exp_v) begin
         check("out_IR", 64'(bus.out_IR), 64'(q[0].ir));
         check("out_PC_next", 64'(bus.out_PC_next), 64'(q[0].pc));
      end else begin
         check("out_IR_nop", 64'(bus.out_IR), 64'(NOP));
         check("out_PC_next_zero", 64'(bus.out_PC_next), 64'd0);
      end
   endtask

   // One clock: check what the DUT shows, drive new inputs, then advance the model at the edge.
   task automatic cycle(input bit rst_n, input bit fl, input bit iv,
                        input logic [31:0] ir, input logic [31:0] pc, input bit ordy);
      bit acc;
      bit deq;
      ent_t e;
      @(negedge clock);
      if (armed) check_outputs();
      reset         = rst_n;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_IR     = ir;
      bus.in_PC_next = pc;
      bus.out_ready = ordy;
      acc = iv && (q.size() < 2);
      deq = ordy && (q.size() > 0);
      @(posedge clock);
      if (!rst_n) begin
         q.delete();
         armed = 1'b1;
      end else if (fl) begin
         q.delete();
      end else begin
         if (deq) e = q.pop_front();
         if (acc) begin
            e.ir = ir;
            e.pc = pc;
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_IR      = '0;
      bus.in_PC_next = '0;
      bus.out_ready  = 1'b0;

      // reset with an offered instruction that must not be taken
      cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h4, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h4, 1'b1);
      idle(1'b1);

      for (int i = 0; i < 8; i++)
         cycle(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 32'h1000 + 32'(4 * i), 1'b1);
      idle(1'b1);
      idle(1'b1);

      // back-pressure: A2 is refused while full, then re-offered
      cycle(1'b1, 1'b0, 1'b1, 32'hA0, 32'h2A0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 32'hA1, 32'h2A1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hA2, 32'h2A2, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hA2, 32'h2A2, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hA2, 32'h2A2, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 32'hA2, 32'h2A2, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // flush from full with a simultaneous offer
      cycle(1'b1, 1'b0, 1'b1, 32'hB0, 32'h3B0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hB1, 32'h3B1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 32'hB2, 32'h3B2, 1'b0);
      idle(1'b0);
      idle(1'b1);

      // accept and dequeue together while holding one entry
      cycle(1'b1, 1'b0, 1'b1, 32'hC0, 32'h4C0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hC1, 32'h4C1, 1'b1);
      idle(1'b0);
      idle(1'b1);

      // reset while full
      cycle(1'b1, 1'b0, 1'b1, 32'hB3, 32'h3B3, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'hB4, 32'h3B4, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 32'hB5, 32'h3B5, 1'b1);
      idle(1'b1);
      idle(1'b1);

      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 9) < 7),
               $urandom, $urandom,
               ($urandom_range(0, 9) < 6));
      end

      @(negedge clock);
      check_outputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
